// File: rtl/instr_encoder.sv
// RV32I instruction encoder (R-type/LW/SW/BEQ) feeding a 2-entry output FIFO.
// Define INSTR_ENC_CHECK_EN to drop illegal requests and flag them on err_pulse.
module instr_encoder (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic               in_f7b5,
    input  logic signed [12:0] in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [15:0]        out_count,
    output logic               err_pulse
);

    typedef enum logic [1:0] {
        OP_R   = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_BEQ = 2'b11
    } op_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    function automatic logic [31:0] encode(
        input op_t                op,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         funct3,
        input logic               f7b5,
        input logic signed [12:0] imm
    );
        logic [31:0] word;
        case (op)
            OP_R:    word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OPC_R};
            OP_LW:   word = {imm[11:0], rs1, 3'b010, rd, OPC_LW};
            OP_SW:   word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_SW};
            default: word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BEQ};
        endcase
        return word;
    endfunction

`ifdef INSTR_ENC_CHECK_EN
    // Immediates that do not fit the 12-bit field, odd branch offsets and
    // funct7[5] on anything other than SUB/SRA are rejected.
    function automatic logic is_illegal(
        input op_t                op,
        input logic [2:0]         funct3,
        input logic               f7b5,
        input logic signed [12:0] imm
    );
        logic bad;
        case (op)
            OP_R:    bad = f7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
            OP_LW,
            OP_SW:   bad = imm[12] != imm[11];
            default: bad = imm[0];
        endcase
        return bad;
    endfunction
`endif

    logic [31:0] enc_p0;
    logic        illegal_p0;
    logic        accept;
    logic        push;
    logic        pop;

    logic [31:0] fifo_q [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;

    assign enc_p0 = encode(op_t'(in_op), in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm);

`ifdef INSTR_ENC_CHECK_EN
    assign illegal_p0 = is_illegal(op_t'(in_op), in_funct3, in_f7b5, in_imm);
`else
    assign illegal_p0 = 1'b0;
`endif

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_instr = fifo_q[rd_ptr];

    assign accept = in_valid && in_ready;
    assign push   = accept && !illegal_p0;
    assign pop    = out_valid && out_ready;

    // ---- stage p1: FIFO storage, pointers and delivered-word counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            out_count <= 16'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= enc_p0;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                out_count <= out_count + 16'd1;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= accept && illegal_p0;
        end
    end
`else
    assign err_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, backpressure/reset sequences,
// and a randomized run against a queue-based reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [12:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_count;
    logic        err_pulse;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_count(out_count), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [12:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_op     = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_f7b5   = v.f7b5;
        in_imm    = v.imm;
    endtask

    // Reference encoding built from field positions with plain integer arithmetic.
    function automatic logic [31:0] model_enc(input int unsigned op, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int unsigned f3, input int unsigned f7b5,
                                              input int unsigned imm);
        int unsigned w;
        case (op)
            0: w = (f7b5 << 30) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h33;
            1: w = ((imm % 4096) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 32'h03;
            2: w = (((imm / 32) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
                   + ((imm % 32) << 7) + 32'h23;
            default: w = (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25) + (rs2 << 20)
                   + (rs1 << 15) + (((imm / 2) % 16) << 8) + (((imm / 2048) % 2) << 7) + 32'h63;
        endcase
        return w;
    endfunction

    function automatic bit model_illegal(input int unsigned op, input int unsigned f3,
                                         input int unsigned f7b5, input int unsigned imm);
`ifdef INSTR_ENC_CHECK_EN
        int simm;
        simm = (imm >= 4096) ? int'(imm) - 8192 : int'(imm);
        case (op)
            0: return (f7b5 == 1) && (f3 != 0) && (f3 != 5);
            1, 2: return (simm < -2048) || (simm > 2047);
            default: return (imm % 2) == 1;
        endcase
`else
        return (op > 3) && (f3 > 7) && (f7b5 > 1) && (imm > 8191);
`endif
    endfunction

    logic [31:0] q [$];
    logic [15:0] exp_cnt;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'h0000, 32'h402081B3};
        vecs[1] = '{2'd1, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'h1FFC, 32'hFFC12283};
        vecs[2] = '{2'd2, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 13'h0008, 32'h00512423};
        vecs[3] = '{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 32'hFE208CE3};
        vecs[4] = '{2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 13'h0000, 32'h003100B3};
        vecs[5] = '{2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'h07FF, 32'h7FF02083};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(vecs[0]);
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_err", err_pulse, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check("vec_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            check("vec_out_valid", out_valid, 1);
            check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
            step();
            exp_cnt++;
            check("vec_count", out_count, exp_cnt);
            check("vec_drain", out_valid, 0);
        end

        // Backpressure: three requests against a stalled consumer.
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        drive(vecs[0]); #1; check("bp_rdy0", in_ready, 1); step();
        drive(vecs[1]); #1; check("bp_rdy1", in_ready, 1); step();
        drive(vecs[2]); #1; check("bp_full", in_ready, 0); step();
        in_valid = 1'b0;
        check("bp_head", out_instr, vecs[0].exp);
        step();
        check("bp_stable", out_instr, vecs[0].exp);
        check("bp_stable_v", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_full_pop_rdy", in_ready, 0);
        step();
        check("bp_second", out_instr, vecs[1].exp);
        check("bp_cnt1", out_count, 1);
        step();
        check("bp_empty", out_valid, 0);
        check("bp_cnt2", out_count, 2);

        // Asynchronous reset with two words queued.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(vecs[3]); step();
        drive(vecs[4]); step();
        in_valid = 1'b0;
        check("ar_queued", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_count", out_count, 0);
        check("ar_out_instr", out_instr, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step(); step();
        check("ar_no_emit", out_valid, 0);
        check("ar_in_ready", in_ready, 1);

`ifdef INSTR_ENC_CHECK_EN
        in_valid = 1'b1; out_ready = 1'b1;
        drive('{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd5, 32'h0});
        #1;
        check("err_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("err_pulse_hi", err_pulse, 1);
        check("err_no_word", out_valid, 0);
        step();
        check("err_pulse_lo", err_pulse, 0);
        check("err_no_word2", out_valid, 0);
        check("err_count", out_count, 0);
`endif

        // Randomized run against the queue model.
        rst = 1'b1; step(); rst = 1'b0;
        q.delete();
        exp_cnt = 0;
        for (int c = 0; c < 500; c++) begin
            bit push, pop, bad;
            logic [31:0] w;
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_f7b5   = 1'($urandom);
            in_imm    = 13'($urandom);
            #1;
            check("rnd_in_ready", in_ready, q.size() < 2);
            check("rnd_out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) check("rnd_out_instr", out_instr, q[0]);
            push = in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            bad  = push && model_illegal(in_op, in_funct3, in_f7b5, in_imm);
            w    = model_enc(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm);
            step();
            if (pop) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (push && !bad) q.push_back(w);
            check("rnd_err", err_pulse, bad);
            check("rnd_count", out_count, exp_cnt);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock domain; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_op  input  2  instruction class: 00 R-type, 01 LW, 10 SW, 11 BEQ.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 in_funct3  input  3  R-type funct3 (ignored for other classes).
REQ-009 in_f7b5  input  1  R-type funct7 bit 5 (ignored for other classes).
REQ-010 in_imm  input  13  signed immediate; byte offset for LW/SW, branch offset for BEQ.
REQ-011 out_valid  output  1  encoded word available.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 out_instr  output  32  encoded RV32I instruction word.
REQ-014 out_count  output  16  count of words delivered.
REQ-015 err_pulse  output  1  one-cycle illegal-request flag.

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 Encoded words SHALL be held in a 2-entry FIFO; in_ready = FIFO not full; out_valid = FIFO not empty; out_instr = head entry.
REQ-018 An accepted legal request SHALL appear at the output exactly 1 cycle after acceptance when the FIFO was empty (registered, no combinational in->out path).
REQ-019 R-type: {1'b0,in_f7b5,5'b0,rs2,rs1,funct3,rd,7'b0110011}.
REQ-020 LW: {imm[11:0],rs1,3'b010,rd,7'b0000011}.
REQ-021 SW: {imm[11:5],rs2,rs1,3'b010,imm[4:0],7'b0100011}.
REQ-022 BEQ: {imm[12],imm[10:5],rs2,rs1,3'b000,imm[4:1],imm[11],7'b1100011}.
REQ-023 Full FIFO with simultaneous output transfer SHALL still report in_ready=0 (no pass-through on full).
REQ-024 Simultaneous push and pop on a 1-entry FIFO SHALL keep occupancy at 1 with the new word at the head on the next cycle.
REQ-025 FIFO pointers SHALL wrap modulo 2; order SHALL be strictly first-in first-out.
REQ-026 out_count SHALL increment by 1 per output transfer and wrap 16'hFFFF -> 16'h0000.
REQ-027 out_instr SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst assertion, asynchronously: FIFO empty, out_valid=0, out_instr=0, out_count=0, err_pulse=0, in_ready=1 once rst deasserts.
REQ-029 Reset mid-operation SHALL discard all queued words; no partial word SHALL be emitted afterwards.

Configuration
REQ-030 With INSTR_ENC_CHECK_EN defined, requests SHALL be checked: LW/SW illegal if imm[12]!=imm[11]; BEQ illegal if imm[0]=1; R-type illegal if in_f7b5=1 and funct3 not 000 or 101.
REQ-031 With INSTR_ENC_CHECK_EN defined, an illegal request SHALL be accepted (consumed), not written to the FIFO, and err_pulse SHALL be 1 for exactly the cycle after acceptance.
REQ-032 Without INSTR_ENC_CHECK_EN, no checks SHALL occur, every request SHALL be encoded by truncation per REQ-019..022, and err_pulse SHALL be tied 0.

Verification
REQ-033 R-type: op=00, rd=3, rs1=1, rs2=2, f3=000, f7b5=1, out_ready=1 -> next cycle out_instr=32'h402081B3, out_count=1.
REQ-034 LW: op=01, rd=5, rs1=2, imm=-4 -> out_instr=32'hFFC12283; SW: op=10, rs1=2, rs2=5, imm=8 -> 32'h00512423.
REQ-035 BEQ: op=11, rs1=1, rs2=2, imm=-8 -> out_instr=32'hFE208CE3.
REQ-036 Backpressure: out_ready=0, 3 back-to-back requests -> first two accepted, in_ready=0 on the third; release out_ready -> words delivered in order, count=2.
REQ-037 With INSTR_ENC_CHECK_EN: BEQ imm=5 -> err_pulse=1 one cycle, out_valid stays 0; assert rst with 2 words queued -> out_valid=0 and out_count=0 immediately.
